viterbi_scheduler: RTL and testbench

VITERBI_SCHEDULER -- requirements
Module: viterbi_scheduler

---
 rtl/viterbi_sched_pkg.sv | 12 +
 rtl/rr_free_picker.sv | 29 ++
 rtl/viterbi_scheduler.sv | 100 ++++++++++
 tb/tb_viterbi_scheduler.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/viterbi_sched_pkg.sv
// Shared types and defaults for the Viterbi engine scheduler.
package viterbi_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } sched_state_t;

    localparam int unsigned DROP_CNT_WIDTH_DEFAULT = 16;

endpackage

// File: rtl/rr_free_picker.sv
// First-free search starting at a rotating pointer, with wrap-around.
module rr_free_picker #(
    parameter int unsigned width     = 4,
    parameter int unsigned ptr_width = 2
) (
    input  logic [width-1:0]     free,
    input  logic [ptr_width-1:0] ptr,
    output logic [width-1:0]     grant,
    output logic                 any_free
);

    always_comb begin
        logic                 found;
        logic [ptr_width-1:0] idx;
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < width; i++) begin
            idx = ptr_width'((32'(ptr) + i) % width);
            if (!found && free[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    assign any_free = |free;

endmodule

// File: rtl/viterbi_scheduler.sv
// Assigns error frames to a pool of Viterbi engines round-robin; tracks busy engines and drain.
// Define VITERBI_SCHED_STALL_EN to back-pressure frames when all engines are busy instead of dropping.
module viterbi_scheduler
    import viterbi_sched_pkg::*;
#(
    parameter int unsigned num_of_viterbis = 4,
    parameter int unsigned drop_cnt_width  = DROP_CNT_WIDTH_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       flush,
    input  logic                       frm_valid,
    input  logic                       frm_err,
    output logic                       frm_ready,
    output logic [num_of_viterbis-1:0] tag,
    output logic                       tag_push,
    output logic [num_of_viterbis-1:0] vit_start,
    input  logic [num_of_viterbis-1:0] vit_release,
    output logic [num_of_viterbis-1:0] busy,
    output logic                       flush_done,
    output logic [drop_cnt_width-1:0]  drop_cnt,
    output logic [1:0]                 sched_state
);

    localparam int unsigned PTR_W = (num_of_viterbis > 1) ? $clog2(num_of_viterbis) : 1;

    sched_state_t               state, state_next;
    logic [PTR_W-1:0]           rr_ptr, rr_next, grant_idx;
    logic [num_of_viterbis-1:0] pick, grant;
    logic                       any_free, accept, drop_event;

    rr_free_picker #(
        .width     (num_of_viterbis),
        .ptr_width (PTR_W)
    ) u_picker (
        .free     (~busy),
        .ptr      (rr_ptr),
        .grant    (pick),
        .any_free (any_free)
    );

`ifdef VITERBI_SCHED_STALL_EN
    assign frm_ready  = (state == RUN) && (busy != '1);
    assign drop_event = 1'b0;
`else
    assign frm_ready  = (state == RUN);
    assign drop_event = accept && frm_err && !any_free;
`endif

    assign accept      = frm_valid && frm_ready;
    assign grant       = (accept && frm_err && any_free) ? pick : '0;
    assign sched_state = state;

    always_comb begin
        grant_idx = '0;
        for (int unsigned i = 0; i < num_of_viterbis; i++) begin
            if (grant[i]) grant_idx = PTR_W'(i);
        end
        rr_next = (32'(grant_idx) == num_of_viterbis - 1) ? '0 : PTR_W'(32'(grant_idx) + 1);
    end

    always_comb begin
        state_next = state;
        flush_done = 1'b0;
        case (state)
            IDLE:    if (flush) state_next = DRAIN;
                     else if (en) state_next = RUN;
            RUN:     if (flush) state_next = DRAIN;
                     else if (!en) state_next = IDLE;
            DRAIN:   if (busy == '0) begin
                         state_next = IDLE;
                         flush_done = !rst;
                     end
            default: state_next = IDLE;
        endcase
    end

    // Release clears only engines already busy; a grant uses pre-release busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= '0;
            rr_ptr    <= '0;
            drop_cnt  <= '0;
            tag       <= '0;
            tag_push  <= 1'b0;
            vit_start <= '0;
        end else begin
            state     <= state_next;
            busy      <= (busy & ~vit_release) | grant;
            tag       <= grant;
            tag_push  <= accept;
            vit_start <= grant;
            if (|grant) rr_ptr <= rr_next;
            if (drop_event && (drop_cnt != '1)) drop_cnt <= drop_cnt + drop_cnt_width'(1);
        end
    end

endmodule

// File: tb/tb_viterbi_scheduler.sv
// Directed self-checking bench for viterbi_scheduler; a second narrow-counter instance checks drop saturation.
module tb_viterbi_scheduler;

    logic        clk = 1'b0;
    logic        rst, en, flush, frm_valid, frm_err;
    logic [3:0]  vit_release;
    logic        frm_ready, tag_push, flush_done;
    logic [3:0]  tag, vit_start, busy;
    logic [15:0] drop_cnt;
    logic [1:0]  sched_state;

    logic        s_frm_ready, s_tag_push, s_flush_done;
    logic [3:0]  s_tag, s_vit_start, s_busy;
    logic [1:0]  s_drop_cnt;
    logic [1:0]  s_sched_state;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 clk = ~clk;

    viterbi_scheduler #(.num_of_viterbis(4), .drop_cnt_width(16)) u_dut (
        .clk(clk), .rst(rst), .en(en), .flush(flush),
        .frm_valid(frm_valid), .frm_err(frm_err), .frm_ready(frm_ready),
        .tag(tag), .tag_push(tag_push), .vit_start(vit_start),
        .vit_release(vit_release), .busy(busy), .flush_done(flush_done),
        .drop_cnt(drop_cnt), .sched_state(sched_state)
    );

    viterbi_scheduler #(.num_of_viterbis(4), .drop_cnt_width(2)) u_dut_small (
        .clk(clk), .rst(rst), .en(en), .flush(flush),
        .frm_valid(frm_valid), .frm_err(frm_err), .frm_ready(s_frm_ready),
        .tag(s_tag), .tag_push(s_tag_push), .vit_start(s_vit_start),
        .vit_release(vit_release), .busy(s_busy), .flush_done(s_flush_done),
        .drop_cnt(s_drop_cnt), .sched_state(s_sched_state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_grant(input string name, input logic [3:0] exp);
        check({name, "_vit_start"}, 32'(vit_start), 32'(exp));
        check({name, "_tag"}, 32'(tag), 32'(exp));
        check({name, "_tag_push"}, 32'(tag_push), 32'd1);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; flush = 1'b0; frm_valid = 1'b0; frm_err = 1'b0; vit_release = 4'b0;
        step(); step();
        rst = 1'b0;
        step();
        check("rst_state", 32'(sched_state), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_tag", 32'(tag), 32'd0);
        check("rst_tag_push", 32'(tag_push), 32'd0);
        check("rst_vit_start", 32'(vit_start), 32'd0);
        check("rst_drop", 32'(drop_cnt), 32'd0);
        check("rst_ready", 32'(frm_ready), 32'd0);
        check("rst_flush_done", 32'(flush_done), 32'd0);

        en = 1'b1;
        step();
        check("run_state", 32'(sched_state), 32'd1);
        check("run_ready", 32'(frm_ready), 32'd1);

        frm_valid = 1'b1; frm_err = 1'b0;
        step();
        check("noerr_tag_push", 32'(tag_push), 32'd1);
        check("noerr_tag", 32'(tag), 32'd0);
        check("noerr_vit_start", 32'(vit_start), 32'd0);

        frm_err = 1'b1;
        step(); check_grant("g0", 4'b0001);
        step(); check_grant("g1", 4'b0010);
        step(); check_grant("g2", 4'b0100);
        step(); check_grant("g3", 4'b1000);
        check("full_busy", 32'(busy), 32'hF);

        step();
`ifdef VITERBI_SCHED_STALL_EN
        check("full_tag_push", 32'(tag_push), 32'd0);
        check("full_ready", 32'(frm_ready), 32'd0);
        check("full_drop", 32'(drop_cnt), 32'd0);
`else
        check("drop1_tag_push", 32'(tag_push), 32'd1);
        check("drop1_tag", 32'(tag), 32'd0);
        check("drop1_drop", 32'(drop_cnt), 32'd1);
`endif
        check("full_vit_start", 32'(vit_start), 32'd0);

        vit_release = 4'b0100;
        step();
        check("relgrant_vit_start", 32'(vit_start), 32'd0);
        check("relgrant_busy", 32'(busy), 32'hB);
`ifndef VITERBI_SCHED_STALL_EN
        check("relgrant_drop", 32'(drop_cnt), 32'd2);
`endif
        vit_release = 4'b0;
        step();
        check("regrant_vit_start", 32'(vit_start), 32'h4);
        check("regrant_busy", 32'(busy), 32'hF);

        frm_valid = 1'b0;
        step();
        check("quiet_tag_push", 32'(tag_push), 32'd0);
        check("quiet_vit_start", 32'(vit_start), 32'd0);
        check("quiet_tag", 32'(tag), 32'd0);

`ifndef VITERBI_SCHED_STALL_EN
        frm_valid = 1'b1;
        for (int unsigned i = 0; i < 3; i++) begin
            step();
            check("sat_drop_wide", 32'(drop_cnt), 32'(3 + i));
            check("sat_drop_small", 32'(s_drop_cnt), 32'd3);
        end
        frm_valid = 1'b0;
`endif

        vit_release = 4'b1010;
        step();
        check("rel_busy", 32'(busy), 32'h5);
        vit_release = 4'b1000;
        step();
        check("rel_idle_engine_busy", 32'(busy), 32'h5);
        vit_release = 4'b0;
        frm_valid = 1'b1;
        step(); check_grant("rr_wrap3", 4'b1000);
        step(); check_grant("rr_wrap1", 4'b0010);
        frm_valid = 1'b0;

        vit_release = 4'b1100;
        step();
        check("pre_drain_busy", 32'(busy), 32'h3);
        vit_release = 4'b0;
        flush = 1'b1;
        step();
        check("drain_state", 32'(sched_state), 32'd2);
        check("drain_ready", 32'(frm_ready), 32'd0);
        flush = 1'b0; frm_valid = 1'b1; vit_release = 4'b0001;
        step();
        check("drain_no_push", 32'(tag_push), 32'd0);
        check("drain_busy1", 32'(busy), 32'h2);
        check("drain_fd0", 32'(flush_done), 32'd0);
        frm_valid = 1'b0; vit_release = 4'b0010;
        step();
        check("drain_busy0", 32'(busy), 32'd0);
        check("drain_fd1", 32'(flush_done), 32'd1);
        check("drain_state_last", 32'(sched_state), 32'd2);
        vit_release = 4'b0;
        step();
        check("post_drain_state", 32'(sched_state), 32'd0);
        check("post_drain_fd", 32'(flush_done), 32'd0);

        step();
        check("rerun_state", 32'(sched_state), 32'd1);
        frm_valid = 1'b1;
        step(); check_grant("r2", 4'b0100);
        step(); check_grant("r3", 4'b1000);
        step(); check_grant("r0", 4'b0001);
        step(); check_grant("r1", 4'b0010);
        frm_valid = 1'b0; vit_release = 4'b0101;
        step();
        vit_release = 4'b0; frm_valid = 1'b1;
        step(); check_grant("pre_rst_g2", 4'b0100);
        frm_valid = 1'b0; vit_release = 4'b0100;
        step();
        check("pre_rst_busy", 32'(busy), 32'hA);
        vit_release = 4'b0;

        rst = 1'b1;
        step();
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_state", 32'(sched_state), 32'd0);
        check("mid_rst_outs", {20'd0, tag, vit_start, 2'b0, tag_push, flush_done}, 32'd0);
        check("mid_rst_drop", 32'(drop_cnt), 32'd0);
        check("mid_rst_drop_small", 32'(s_drop_cnt), 32'd0);
        rst = 1'b0;
        step();
        check("post_rst_state", 32'(sched_state), 32'd1);
        frm_valid = 1'b1;
        step(); check_grant("post_rst_g0", 4'b0001);
        frm_valid = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
